// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, RISC-V width
// codes, memory write-enable codes and the request legality check.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_BYTE = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b011;
    localparam logic [2:0] WE_WORD = 3'b111;

    // Unsigned/extended widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic req_illegal(logic is_store, logic [2:0] funct3, logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] write_enable_code(logic [2:0] funct3);
        logic [2:0] code;
        case (funct3)
            F3_B:    code = WE_BYTE;
            F3_H:    code = WE_HALF;
            F3_W:    code = WE_WORD;
            default: code = WE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Reassembles the memory read lanes into a little-endian value and applies
// sign or zero extension according to the load width code.
module load_store_unit_load_extend
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [2:0]             funct3,
    input  logic [WORD_LENGTH-1:0] raw,
    output logic [WORD_LENGTH-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] word_val;
    logic [31:0] ext;

    // Memory presents the addressed byte in the top lane, later bytes below it.
    assign byte_val = raw[31:24];
    assign half_val = {raw[23:16], raw[31:24]};
    assign word_val = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};

    always_comb begin
        ext = word_val;
        case (funct3)
            F3_B:    ext = {{24{byte_val[7]}}, byte_val};
            F3_H:    ext = {{16{half_val[15]}}, half_val};
            F3_BU:   ext = {24'd0, byte_val};
            F3_HU:   ext = {16'd0, half_val};
            default: ext = word_val;
        endcase
    end

    assign data = WORD_LENGTH'(ext);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request/response handshake
// and a byte-addressed memory with a combinational read port.
//
// state     | meaning
// ST_IDLE   | ready for a request; latches it on req_valid
// ST_ACCESS | one-cycle memory strobe; load data captured at cycle end
// ST_RESP   | response held until resp_ready
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [2:0]             req_funct3,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WORD_LENGTH-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_LENGTH-1:0] resp_rdata,
    output logic                   resp_error,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [WORD_LENGTH-1:0] mem_write_data,
    output logic [2:0]             mem_write_enable,
    output logic                   mem_read_enable,
    input  logic [WORD_LENGTH-1:0] mem_data_out
);

    lsu_state_t             state, state_nxt;
    logic                   is_store_q;
    logic [2:0]             funct3_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic [WORD_LENGTH-1:0] rdata_q;
    logic                   error_q;
    logic                   req_bad;
    logic [WORD_LENGTH-1:0] load_data;

    assign req_bad = req_illegal(req_is_store, req_funct3, req_addr[1:0]);

    load_store_unit_load_extend #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_load_extend (
        .funct3(funct3_q),
        .raw   (mem_data_out),
        .data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
                error_q    <= req_bad;
            end
            if (state == ST_ACCESS && !is_store_q) begin
                rdata_q <= load_data;
            end
        end
    end

    // Outputs are gated by rst as well so they collapse without waiting for a clock.
    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        resp_error       = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = WE_NONE;
        mem_read_enable  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_ACCESS: begin
                    mem_address = addr_q;
                    if (is_store_q) begin
                        mem_write_enable = write_enable_code(funct3_q);
                        mem_write_data   = wdata_q;
                    end else begin
                        mem_read_enable = 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_error = error_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory model, vector table of
// transactions with a response scoreboard, plus stall and reset sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_data_out;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_enable (mem_read_enable),
        .mem_data_out    (mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian byte memory: addr in the top lane of the read port.
    logic [7:0] mem [0:255];
    logic [7:0] ma0, ma1, ma2, ma3;
    assign ma0 = mem_address[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;
    assign mem_data_out = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};

    always @(posedge clk) begin
        if (mem_write_enable[0]) mem[ma0] <= mem_write_data[7:0];
        if (mem_write_enable[1]) mem[ma1] <= mem_write_data[15:8];
        if (mem_write_enable[2]) begin
            mem[ma2] <= mem_write_data[23:16];
            mem[ma3] <= mem_write_data[31:24];
        end
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  exp_we;
        logic [31:0] exp_rdata;
        logic        exp_error;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_valid    = 1'b1;
        req_is_store = v.is_store;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    // Waits for a response, compares it with the scoreboard head and completes the handshake.
    task automatic wait_resp();
        exp_t e;
        int n;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_valid_seen", resp_valid, 1);
        chk("resp_latency", n, 0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", resp_error, e.error);
        end
        chk("req_ready_in_resp", req_ready, 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_after_hs", resp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        drive_req(v);
        #1 chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_q.push_back('{rdata: v.exp_rdata, error: v.exp_error});
        if (v.exp_error) begin
            chk("err_no_we", mem_write_enable, 3'b000);
            chk("err_no_re", mem_read_enable, 0);
        end else begin
            chk("acc_addr", mem_address, v.addr);
            chk("acc_we", mem_write_enable, v.exp_we);
            chk("acc_re", mem_read_enable, !v.is_store);
            if (v.is_store) chk("acc_wdata", mem_write_data, v.wdata);
            chk("acc_no_resp", resp_valid, 0);
            chk("acc_req_ready", req_ready, 0);
            @(posedge clk); #1;
            chk("post_acc_we", mem_write_enable, 3'b000);
        end
        wait_resp();
    endtask

    initial begin
        vec_t v;
        exp_t held;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //            st    f3      addr    wdata         we      rdata         err
        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 3'b111, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        3'b000, 32'hA1B2C3D4, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h05, 32'h000000F0, 3'b001, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h05, 32'h0,        3'b000, 32'hFFFFFFF0, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h05, 32'h0,        3'b000, 32'h000000F0, 1'b0};
        vecs[5]  = '{1'b1, 3'b001, 32'h06, 32'h00008001, 3'b011, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h06, 32'h0,        3'b000, 32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h06, 32'h0,        3'b000, 32'h00008001, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 32'h04, 32'h0,        3'b000, 32'h8001F000, 1'b0};
        vecs[9]  = '{1'b0, 3'b000, 32'h12, 32'h0,        3'b000, 32'hFFFFFFB2, 1'b0};
        vecs[10] = '{1'b0, 3'b101, 32'h12, 32'h0,        3'b000, 32'h0000A1B2, 1'b0};
        vecs[11] = '{1'b1, 3'b000, 32'h11, 32'h12345677, 3'b001, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 3'b010, 32'h10, 32'h0,        3'b000, 32'hA1B277D4, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h0E, 32'h0,        3'b000, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 3'b011, 32'h00, 32'h0,        3'b000, 32'h0,        1'b1};
        vecs[15] = '{1'b1, 3'b100, 32'h08, 32'h000000FF, 3'b000, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 3'b001, 32'h07, 32'h0,        3'b000, 32'h0,        1'b1};
        vecs[17] = '{1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, 3'b000, 32'h0,        1'b1};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;

        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_we", mem_write_enable, 3'b000);
        chk("rst_re", mem_read_enable, 0);
        chk("rst_addr", mem_address, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", req_ready, 1);

        for (int i = 0; i < 18; i++) run_txn(vecs[i]);

        chk("err_store_no_write", mem_word(8'h08), 32'h0);
        chk("err_sw_no_write", mem_word(8'h00), 32'h0);

        // Response stall with a competing request that must be ignored.
        v = vecs[12];
        @(negedge clk);
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_q.push_back('{rdata: v.exp_rdata, error: 1'b0});
        @(posedge clk); #1;
        held = sb_q[0];
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'h20;
        req_wdata    = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            chk("stall_resp_valid", resp_valid, 1);
            chk("stall_rdata", resp_rdata, held.rdata);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_we", mem_write_enable, 3'b000);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_resp();
        @(posedge clk); #1;
        chk("stall_req_ignored", mem_word(8'h20), 32'h0);

        // Reset in the middle of a store's access cycle.
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'h30;
        req_wdata    = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_acc_we_before", mem_write_enable, 3'b111);
        #2 rst = 1'b1;
        #1;
        chk("rst_acc_we_drop", mem_write_enable, 3'b000);
        chk("rst_acc_req_ready", req_ready, 0);
        chk("rst_acc_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        chk("rst_hold_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_no_resp", resp_valid, 0);
            chk("rst_idle_ready", req_ready, 1);
        end
        chk("rst_store_dropped", mem_word(8'h30), 32'h0);

        run_txn(vecs[12]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
